// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: pin sync, clock de-glitch, 11-bit framing, Set-2 F0/E0 prefix stripping.
// Optional PS2_RX_PARITY_EN: when defined, odd parity is enforced; otherwise the parity bit is ignored.
module ps2_scancode_rx #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 12000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       released,
  output logic       extended,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;

  // Synchronisers reset to the idle-high line level so reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
    end
  end

  logic       fclk_q, fclk_d;
  logic [7:0] flt_cnt_q, flt_cnt_d;
  logic       fall;

  always_comb begin
    fclk_d    = fclk_q;
    flt_cnt_d = '0;
    fall      = 1'b0;
    if (clk_s2_q != fclk_q) begin
      if (flt_cnt_q == 8'(FILTER_LEN - 1)) begin
        fclk_d = ~fclk_q;
        fall   = fclk_q;
      end else begin
        flt_cnt_d = flt_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fclk_q    <= 1'b1;
      flt_cnt_q <= '0;
    end else begin
      fclk_q    <= fclk_d;
      flt_cnt_q <= flt_cnt_d;
    end
  end

  state_t        state_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          parity_ok_q;
  logic [TW-1:0] tmo_q;
  logic          rel_q, ext_q;
  logic [7:0]    code_q;
  logic          code_valid_q, released_q, extended_q, frame_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_ok_q  <= 1'b0;
      tmo_q        <= '0;
      rel_q        <= 1'b0;
      ext_q        <= 1'b0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
      released_q   <= 1'b0;
      extended_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;

      if (state_q == S_IDLE || fall) tmo_q <= '0;
      else                           tmo_q <= tmo_q + TW'(1);

      // Timeout wins only when no edge arrives in the same cycle; sticky prefixes survive.
      if (state_q != S_IDLE && !fall && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        frame_err_q <= 1'b1;
        state_q     <= S_IDLE;
      end else if (fall) begin
        case (state_q)
          S_IDLE: begin
            if (!dat_s2_q) begin
              state_q   <= S_DATA;
              bit_cnt_q <= '0;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
          S_DATA: begin
            shift_q   <= {dat_s2_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= S_PARITY;
          end
          S_PARITY: begin
`ifdef PS2_RX_PARITY_EN
            parity_ok_q <= ^{dat_s2_q, shift_q};
`else
            parity_ok_q <= 1'b1;
`endif
            state_q <= S_STOP;
          end
          S_STOP: begin
            state_q <= S_IDLE;
            if (dat_s2_q && parity_ok_q) begin
              if (shift_q == 8'hF0) begin
                rel_q <= 1'b1;
              end else if (shift_q == 8'hE0) begin
                ext_q <= 1'b1;
              end else begin
                code_q       <= shift_q;
                released_q   <= rel_q;
                extended_q   <= ext_q;
                code_valid_q <= 1'b1;
                rel_q        <= 1'b0;
                ext_q        <= 1'b0;
              end
            end else begin
              frame_err_q <= 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign code       = code_q;
  assign code_valid = code_valid_q;
  assign released   = released_q;
  assign extended   = extended_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Self-checking bench for ps2_scancode_rx: directed scenarios plus randomized back-to-back frames.
module tb_ps2_scancode_rx;

  localparam int unsigned FLT = 8;
  localparam int unsigned TMO = 12000;
`ifdef PS2_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, ps2_clk, ps2_data;
  logic [7:0] code;
  logic       code_valid, released, extended, frame_err, busy;

  ps2_scancode_rx #(.FILTER_LEN(FLT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .code(code), .code_valid(code_valid), .released(released), .extended(extended),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Observed events {released, extended, code} and error pulses.
  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];
  int         err_cnt = 0;
  int         exp_err = 0;
  logic       prev_cv = 1'b0;

  // Reference model state: sticky prefix flags as seen by the keyboard protocol.
  bit m_rel = 1'b0;
  bit m_ext = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (code_valid) begin
        got_q.push_back({released, extended, code});
        total++;
        if (frame_err || prev_cv) begin
          bad++;
          $display("FAIL strobe_shape cv=%0b prev_cv=%0b err=%0b want single-cycle cv without err",
                   code_valid, prev_cv, frame_err);
        end
      end
      if (frame_err) err_cnt++;
    end
    prev_cv = code_valid;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog sim_time=%0t limit=3ms", $time);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Drives the first nbits bits of a frame; each bit: set data, wait half, fall, wait half, rise.
  task automatic send_frame(input logic [7:0] b, input int half, input bit bad_par,
                            input bit bad_stop, input int nbits);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      wait_cyc(half);
      ps2_clk = 1'b0;
      wait_cyc(half);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  // Protocol-level expectation for one full frame.
  task automatic model_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    if (bad_stop || (PAR_EN && bad_par)) exp_err++;
    else if (b == 8'hF0) m_rel = 1'b1;
    else if (b == 8'hE0) m_ext = 1'b1;
    else begin
      exp_q.push_back({m_rel, m_ext, b});
      m_rel = 1'b0;
      m_ext = 1'b0;
    end
  endtask

  task automatic frame(input logic [7:0] b, input int half, input bit bad_par, input bit bad_stop);
    send_frame(b, half, bad_par, bad_stop, 11);
    model_frame(b, bad_par, bad_stop);
  endtask

  task automatic test_reset;
    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    wait_cyc(4);
    @(negedge clk);
    total++;
    if ({code, code_valid, released, extended, frame_err, busy} !== 13'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", {code, code_valid, released, extended, frame_err, busy});
    end
    reset = 1'b0;
    wait_cyc(20);
    @(negedge clk);
    total++;
    if ({code_valid, frame_err, busy} !== 3'b000) begin
      bad++;
      $display("FAIL post_reset_idle got=%b want=000", {code_valid, frame_err, busy});
    end
  endtask

  task automatic test_single;
    frame(8'h1C, 240, 1'b0, 1'b0);
    wait_cyc(40);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL single_count got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL single_event got=%h want=%h", got_q[i], exp_q[i]);
      end
    end
    total++;
    if (err_cnt !== exp_err) begin
      bad++; $display("FAIL single_err got=%0d want=%0d", err_cnt, exp_err);
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_prefix;
    frame(8'hF0, 30, 1'b0, 1'b0);
    frame(8'h1C, 30, 1'b0, 1'b0);
    frame(8'h1C, 30, 1'b0, 1'b0);
    frame(8'hE0, 30, 1'b0, 1'b0);
    frame(8'hF0, 30, 1'b0, 1'b0);
    frame(8'h75, 30, 1'b0, 1'b0);
    frame(8'hE1, 30, 1'b0, 1'b0);
    frame(8'hAA, 30, 1'b0, 1'b0);
    frame(8'hFA, 30, 1'b0, 1'b0);
    wait_cyc(40);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL prefix_count got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL prefix_event[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
      end
    end
    total++;
    if (err_cnt !== exp_err) begin
      bad++; $display("FAIL prefix_err got=%0d want=%0d", err_cnt, exp_err);
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_parity;
    frame(8'h1C, 30, 1'b1, 1'b0);
    frame(8'h33, 30, 1'b0, 1'b1);
    wait_cyc(40);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL parity_count got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL parity_event got=%h want=%h", got_q[i], exp_q[i]);
      end
    end
    total++;
    if (err_cnt !== exp_err) begin
      bad++; $display("FAIL parity_err got=%0d want=%0d", err_cnt, exp_err);
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_timeout;
    int  err_at;
    int  err0;
    frame(8'hF0, 30, 1'b0, 1'b0);
    // Start bit + 4 data bits, last bit's rise is suppressed so the last fall time is known.
    send_frame(8'h29, 30, 1'b0, 1'b0, 4);
    ps2_data = 1'b1;
    wait_cyc(30);
    err0 = err_cnt;
    ps2_clk = 1'b0;
    err_at = -1;
    for (int c = 1; c <= 13000; c++) begin
      @(negedge clk);
      if (c == 30) ps2_clk = 1'b1;
      if (c == 100) begin
        total++;
        if (busy !== 1'b1) begin
          bad++; $display("FAIL timeout_busy_mid got=%b want=1", busy);
        end
      end
      if (err_at < 0 && err_cnt != err0) err_at = c;
    end
    exp_err++;
    // Fall reaches the FSM after 2 sync + FILTER_LEN cycles; then TIMEOUT cycles of silence.
    total++;
    if (err_at < int'(TMO + FLT) || err_at > int'(TMO + FLT + 6)) begin
      bad++; $display("FAIL timeout_latency got=%0d want=%0d..%0d", err_at, TMO + FLT, TMO + FLT + 6);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL timeout_busy_after got=%b want=0", busy);
    end
    frame(8'h29, 30, 1'b0, 1'b0);
    wait_cyc(40);
    total++;
    if (got_q.size() != 1 || exp_q.size() != 1) begin
      bad++; $display("FAIL timeout_count got=%0d want=%0d", got_q.size(), exp_q.size());
    end else begin
      total++;
      if (got_q[0] !== exp_q[0]) begin
        bad++; $display("FAIL timeout_next_event got=%h want=%h", got_q[0], exp_q[0]);
      end
    end
    total++;
    if (err_cnt !== exp_err) begin
      bad++; $display("FAIL timeout_err got=%0d want=%0d", err_cnt, exp_err);
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_bad_start;
    ps2_data = 1'b1;
    wait_cyc(30);
    ps2_clk = 1'b0;
    wait_cyc(30);
    ps2_clk = 1'b1;
    exp_err++;
    wait_cyc(30);
    total++;
    if (err_cnt !== exp_err || busy !== 1'b0) begin
      bad++; $display("FAIL bad_start err=%0d busy=%b want err=%0d busy=0", err_cnt, busy, exp_err);
    end
  endtask

  task automatic test_glitch_reset;
    for (int g = 0; g < 5; g++) begin
      ps2_clk = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
      wait_cyc(20);
    end
    total++;
    if (err_cnt !== exp_err || busy !== 1'b0 || got_q.size() != 0) begin
      bad++; $display("FAIL glitch err=%0d busy=%b events=%0d want err=%0d busy=0 events=0",
                      err_cnt, busy, got_q.size(), exp_err);
    end
    frame(8'hF0, 30, 1'b0, 1'b0);
    send_frame(8'h5A, 30, 1'b0, 1'b0, 6);
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL midframe_busy got=%b want=1", busy);
    end
    reset = 1'b1;
    m_rel = 1'b0;
    m_ext = 1'b0;
    wait_cyc(3);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({code, code_valid, released, extended, frame_err, busy} !== 13'd0) begin
      bad++; $display("FAIL midframe_reset got=%h want=0", {code, code_valid, released, extended, frame_err, busy});
    end
    wait_cyc(30);
    frame(8'h5A, 30, 1'b0, 1'b0);
    wait_cyc(40);
    total++;
    if (got_q.size() != 1 || exp_q.size() != 1) begin
      bad++; $display("FAIL reset_next_count got=%0d want=%0d", got_q.size(), exp_q.size());
    end else begin
      total++;
      if (got_q[0] !== exp_q[0]) begin
        bad++; $display("FAIL reset_next_event got=%h want=%h", got_q[0], exp_q[0]);
      end
    end
    total++;
    if (err_cnt !== exp_err) begin
      bad++; $display("FAIL reset_err got=%0d want=%0d", err_cnt, exp_err);
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back;
    logic [7:0] b;
    int         r;
    bit         bp, bs;
    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 99);
      if (r < 20)      b = 8'hF0;
      else if (r < 35) b = 8'hE0;
      else             b = 8'($urandom_range(0, 255));
      bp = ($urandom_range(0, 7) == 0);
      bs = ($urandom_range(0, 9) == 0);
      frame(b, $urandom_range(15, 40), bp, bs);
    end
    wait_cyc(40);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL b2b_count got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL b2b_event[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
      end
    end
    total++;
    if (err_cnt !== exp_err) begin
      bad++; $display("FAIL b2b_err got=%0d want=%0d", err_cnt, exp_err);
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_prefix();
    test_parity();
    test_timeout();
    test_bad_start();
    test_glitch_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
